store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
Posted-write buffer between the pipeline's memory stage and data memory. Captures word stores presented on MemWrite/DataAdr/WriteData and drains them in order to data memory over a valid/ready port, freeing the pipeline from memory write latency. Forwards buffered data to loads that hit a pending store. Sits directly downstream of the core's store bus, which is the bus the system bench monitors.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2.
AW, 32, address width.
DW, 32, data width; word stores only.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
MemWrite  in  1  store request from the memory stage.
DataAdr  in  AW  store or load byte address; bits [1:0] are ignored.
WriteData  in  DW  store data.
MemRead  in  1  load request from the memory stage; uses DataAdr.
StallM  out  1  store not accepted; pipeline must hold the memory stage.
LoadHit  out  1  the load matches a buffered store.
LoadData  out  DW  forwarded data; valid when LoadHit=1.
MemWe  out  1  drain request; equals buffer non-empty.
MemAdr  out  AW  head entry address, forced word-aligned ({adr[AW-1:2],2'b00}).
MemWData  out  DW  head entry data.
MemReady  in  1  memory accepts the head entry this cycle.
Count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, immediate): all entries invalid; head and tail pointers at 0; Count=0; MemWe=0; StallM=0; LoadHit=0; LoadData=0.
- Reset mid-drain: pending stores are discarded and never written. This is intentional.
- Storage: circular FIFO of {word address [AW-1:2], data}.
- Head/tail pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
  - full = (MSBs differ) and (low bits equal).
  - empty = (pointers equal).
  - Pointers wrap naturally at DEPTH.
- Push: when MemWrite & !full, the entry is written at tail on the rising edge; tail increments.
- StallM = MemWrite & full, combinational. It depends on full only, not on MemReady. A store arriving while full is therefore stalled, even if a pop happens in the same cycle; it is accepted the next cycle.
- Pop: when MemWe & MemReady, head increments on the rising edge.
  - MemAdr/MemWData always reflect the head entry combinationally.
  - When empty, MemAdr and MemWData are 0.
- Simultaneous push and pop when not full and not empty: both occur; Count is unchanged.
- Simultaneous push and pop when empty: push only. MemWe is 0 that cycle; the new entry appears at head next cycle, giving 1-cycle minimum store-to-memory latency.
- Count: +1 on push-only, -1 on pop-only, otherwise unchanged.
- Forwarding (combinational, same cycle):
  - When MemRead=1, compare DataAdr[AW-1:2] against all occupied entries.
  - LoadHit=1 if any entry matches; LoadData is taken from the youngest match (closest to tail).
  - The head entry being popped this cycle still forwards.
  - If MemRead=0 or there is no match: LoadHit=0, LoadData=0.
- MemWrite and MemRead asserted together is illegal. Add an assertion; the store takes priority and LoadHit is forced to 0.
- No reordering or write coalescing: duplicate addresses occupy separate entries and drain in order.

Decomposition:
- Package store_buffer_pkg:
  - sb_entry_t struct {logic [AW-3:0] wadr; logic [DW-1:0] data;}.
  - Constants SB_DEPTH=4 and SB_PTRW=$clog2(SB_DEPTH)+1.
- One sub-module: sb_fwd_match. It takes the entry array, occupancy vector, head index and load word address, and returns hit plus youngest-match data via a priority scan from tail-1 backward.
- FIFO pointer logic stays in the top module.

Test Plan:
- Reset then idle -> Count=0, MemWe=0, StallM=0, LoadHit=0 every cycle. Assert reset mid-drain with 3 entries -> Count=0 immediately, no further MemWe.
- Single store DataAdr=132, WriteData=32'hABCDE02E, MemReady=1 -> next cycle MemWe=1, MemAdr=132, MemWData=32'hABCDE02E; the cycle after, Count=0.
- MemReady=0, five stores to 0x100,0x104,0x108,0x10C,0x110 -> first four accepted, Count=4; StallM=1 on the fifth. Raise MemReady -> drains in order 0x100..0x10C; fifth accepted once full deasserts.
- Stores 0x200<-1, 0x200<-2 (MemReady=0), then load 0x202 -> LoadHit=1, LoadData=2 (youngest, word-aligned compare). Load 0x204 -> LoadHit=0.
- Continuous push and pop at full rate for 3*DEPTH cycles across pointer wrap -> Count constant at 1, every datum appears on MemWData exactly once in order.
- Store to DataAdr=0x7 -> MemAdr=0x4.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
//   SB_DEPTH     default number of buffered stores
//   SB_PTRW      head/tail pointer width (index bits plus one wrap bit)
//   SB_AW/SB_DW  address and data widths of a buffered entry
//   sb_entry_t   one buffered store: word address (byte bits dropped) and data
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTRW  = $clog2(SB_DEPTH) + 1;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-3:0] wadr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding match for the store buffer.
// Compares a load word address against every occupied entry and returns the
// data of the youngest matching entry.
//   entries   entry storage array
//   occupied  one bit per slot, set when the slot holds a pending store
//   head      slot index of the oldest entry
//   wadr      load word address
//   hit       at least one occupied entry matches
//   data      data of the youngest match, 0 when no hit
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int IW   = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] occupied,
    input  logic [IW-1:0]    head,
    input  logic [SB_AW-3:0] wadr,
    output logic             hit,
    output logic [SB_DW-1:0] data
);

    logic [IW-1:0] idx;

    // Walk from oldest to youngest; a later match overwrites an earlier one,
    // which gives the same priority as scanning backward from tail-1.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + IW'(i);
            if (occupied[idx] && (entries[idx].wadr == wadr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and data memory.
// Captures word stores into an in-order circular FIFO, drains them over a
// valid/ready port and forwards pending store data to matching loads.
//   clk, reset                      clock, async active-high reset
//   MemWrite/DataAdr/WriteData      store request from the memory stage
//   MemRead                         load request (address on DataAdr)
//   StallM                          store refused because the buffer is full
//   LoadHit/LoadData                forwarded load result
//   MemWe/MemAdr/MemWData/MemReady  drain port to data memory
//   Count                           occupied entries
// AW and DW must match the entry widths in store_buffer_pkg.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWrite,
    input  logic [AW-1:0]        DataAdr,
    input  logic [DW-1:0]        WriteData,
    input  logic                 MemRead,
    output logic                 StallM,
    output logic                 LoadHit,
    output logic [DW-1:0]        LoadData,
    output logic                 MemWe,
    output logic [AW-1:0]        MemAdr,
    output logic [DW-1:0]        MemWData,
    input  logic                 MemReady,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PTRW = $clog2(DEPTH) + 1;
    localparam int IW   = PTRW - 1;

    sb_entry_t        entries [DEPTH];
    logic [PTRW-1:0]  head;
    logic [PTRW-1:0]  tail;
    logic [PTRW-1:0]  count;
    logic [IW-1:0]    head_idx;
    logic [IW-1:0]    tail_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] occupied;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign full     = (head[PTRW-1] != tail[PTRW-1]) && (head_idx == tail_idx);
    assign empty    = (head == tail);
    assign count    = tail - head;
    assign Count    = count;

    // Full is sampled before any same-cycle pop, so a store into a full
    // buffer always waits one cycle.
    assign push   = MemWrite && !full;
    assign pop    = !empty && MemReady;
    assign StallM = MemWrite && full;
    assign MemWe  = !empty;

    assign MemAdr   = empty ? '0 : {entries[head_idx].wadr, 2'b00};
    assign MemWData = empty ? '0 : entries[head_idx].data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    // Entry contents need no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push) entries[tail_idx] <= '{wadr: DataAdr[AW-1:2], data: WriteData};
    end

    // A slot is occupied when its distance from head is below the count.
    always_comb begin
        occupied = '0;
        for (int j = 0; j < DEPTH; j++) begin
            occupied[j] = ({1'b0, IW'(j) - head_idx} < count);
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries  (entries),
        .occupied (occupied),
        .head     (head_idx),
        .wadr     (DataAdr[AW-1:2]),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    // A simultaneous store suppresses forwarding.
    assign LoadHit  = MemRead && !MemWrite && fwd_hit;
    assign LoadData = LoadHit ? fwd_data : '0;

    a_no_read_write: assert property (@(posedge clk) disable iff (reset)
        !(MemWrite && MemRead));

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        StallM;
    logic        LoadHit;
    logic [31:0] LoadData;
    logic        MemWe;
    logic [31:0] MemAdr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [2:0]  Count;

    int errors = 0;
    int checks = 0;

    store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .StallM    (StallM),
        .LoadHit   (LoadHit),
        .LoadData  (LoadData),
        .MemWe     (MemWe),
        .MemAdr    (MemAdr),
        .MemWData  (MemWData),
        .MemReady  (MemReady),
        .Count     (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, " count"},   32'(Count),   32'd0);
        check({tag, " memwe"},   32'(MemWe),   32'd0);
        check({tag, " stallm"},  32'(StallM),  32'd0);
        check({tag, " loadhit"}, 32'(LoadHit), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemReady  = 1'b0;
        #3;
        idle_checks("in_reset");
        check("in_reset loaddata", LoadData, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            idle_checks("idle");
        end

        // single store with ready memory
        MemReady  = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd132;
        WriteData = 32'hABCDE02E;
        #1;
        check("single memwe_before", 32'(MemWe), 32'd0);
        check("single stallm", 32'(StallM), 32'd0);
        tick();
        MemWrite = 1'b0;
        #1;
        check("single memwe", 32'(MemWe), 32'd1);
        check("single memadr", MemAdr, 32'd132);
        check("single memwdata", MemWData, 32'hABCDE02E);
        check("single count", 32'(Count), 32'd1);
        tick();
        check("single drained count", 32'(Count), 32'd0);
        check("single drained memwe", 32'(MemWe), 32'd0);
        check("single empty memadr", MemAdr, 32'd0);

        // fill to full, stall the fifth, then drain in order
        MemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'h100 + 32'(4 * i);
            WriteData = 32'h1000 + 32'(i);
            #1;
            check($sformatf("fill stallm %0d", i), 32'(StallM), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) tick();
        end
        check("fill count", 32'(Count), 32'd4);
        check("fill head adr", MemAdr, 32'h100);
        MemReady = 1'b1;
        #1;
        check("full stall despite pop", 32'(StallM), 32'd1);
        check("full head data", MemWData, 32'h1000);
        tick();
        check("after pop stallm", 32'(StallM), 32'd0);
        check("after pop count", 32'(Count), 32'd3);
        check("after pop memadr", MemAdr, 32'h104);
        tick();
        MemWrite = 1'b0;
        #1;
        check("push_pop count", 32'(Count), 32'd3);
        check("drain memadr 108", MemAdr, 32'h108);
        tick();
        check("drain memadr 10c", MemAdr, 32'h10C);
        check("drain count 2", 32'(Count), 32'd2);
        tick();
        check("drain memadr 110", MemAdr, 32'h110);
        check("drain memwdata 110", MemWData, 32'h1004);
        tick();
        check("drain done count", 32'(Count), 32'd0);
        check("drain done memwe", 32'(MemWe), 32'd0);

        // forwarding
        MemReady = 1'b0;
        MemWrite = 1'b1;
        DataAdr = 32'h300; WriteData = 32'd3; tick();
        DataAdr = 32'h200; WriteData = 32'd1; tick();
        DataAdr = 32'h200; WriteData = 32'd2; tick();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        DataAdr  = 32'h202;
        #1;
        check("fwd youngest hit", 32'(LoadHit), 32'd1);
        check("fwd youngest data", LoadData, 32'd2);
        DataAdr = 32'h204;
        #1;
        check("fwd miss hit", 32'(LoadHit), 32'd0);
        check("fwd miss data", LoadData, 32'd0);
        MemRead = 1'b0;
        DataAdr = 32'h200;
        #1;
        check("fwd noread hit", 32'(LoadHit), 32'd0);
        MemRead  = 1'b1;
        DataAdr  = 32'h300;
        MemReady = 1'b1;
        #1;
        check("fwd popping head hit", 32'(LoadHit), 32'd1);
        check("fwd popping head data", LoadData, 32'd3);
        tick();
        #1;
        check("fwd popped head hit", 32'(LoadHit), 32'd0);
        MemRead = 1'b0;
        tick();
        tick();
        check("fwd drained count", 32'(Count), 32'd0);

        // reset while draining
        MemReady = 1'b0;
        MemWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DataAdr   = 32'h500 + 32'(4 * i);
            WriteData = 32'h5000 + 32'(i);
            tick();
        end
        MemWrite = 1'b0;
        check("pre_reset count", 32'(Count), 32'd3);
        MemReady = 1'b1;
        reset    = 1'b1;
        #1;
        check("mid reset count", 32'(Count), 32'd0);
        check("mid reset memwe", 32'(MemWe), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            idle_checks("post_reset");
        end

        // full-rate push and pop across pointer wrap
        for (int k = 0; k <= 12; k++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'h400 + 32'(4 * k);
            WriteData = 32'hC000 + 32'(k);
            #1;
            if (k == 0) begin
                check("stream first memwe", 32'(MemWe), 32'd0);
            end else begin
                check($sformatf("stream data %0d", k - 1), MemWData, 32'hC000 + 32'(k - 1));
                check($sformatf("stream adr %0d", k - 1), MemAdr, 32'h400 + 32'(4 * (k - 1)));
                check($sformatf("stream count %0d", k), 32'(Count), 32'd1);
            end
            tick();
        end
        MemWrite = 1'b0;
        #1;
        check("stream last data", MemWData, 32'hC00C);
        tick();
        check("stream end count", 32'(Count), 32'd0);

        // unaligned store address is word-aligned on the drain port
        MemReady  = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'h7;
        WriteData = 32'h77;
        tick();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        DataAdr  = 32'h4;
        #1;
        check("unaligned memadr", MemAdr, 32'h4);
        check("unaligned fwd hit", 32'(LoadHit), 32'd1);
        check("unaligned fwd data", LoadData, 32'h77);
        MemRead = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
